// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types: RX state encoding, oversample default, word-length helpers
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int OVERSAMPLE_DEF = 16;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
        return 4'd5 + {2'b00, wls};
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx pin synchronizer chain with falling-edge detect
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Idle-high line: everything resets to 1 so reset release never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s_o = sync_q[SYNC_STAGES-1];
    assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - UART receive engine: start validation, mid-bit sampling, parity/stop check
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick_i,
    input  logic       rx_i,
    input  logic [1:0] lcr_wls_i,
    input  logic       lcr_pen_i,
    input  logic       lcr_eps_i,
    input  logic       rx_ready_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       pe_o,
    output logic       fe_o,
    output logic       bi_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int            TW      = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (rx_i),
        .rx_s_o (rx_s),
        .fall_o (rx_fall)
    );

    rx_state_e     state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          acc_q, acc_d;
    logic          par_bit_q, par_bit_d;
    logic [1:0]    wls_q, wls_d;
    logic          pen_q, pen_d;
    logic          eps_q, eps_d;

    logic          commit_q, commit_d;
    logic          res_pe_q, res_pe_d;
    logic          res_fe_q, res_fe_d;
    logic          res_bi_q, res_bi_d;

    logic          valid_q, valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_pe_q, out_pe_d;
    logic          out_fe_q, out_fe_d;
    logic          out_bi_q, out_bi_d;
    logic          overrun_q, overrun_d;

    logic          bit_done;
    logic          last_data_bit;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        acc_d      = acc_q;
        par_bit_d  = par_bit_q;
        wls_d      = wls_q;
        pen_d      = pen_q;
        eps_d      = eps_q;
        commit_d   = 1'b0;
        res_pe_d   = res_pe_q;
        res_fe_d   = res_fe_q;
        res_bi_d   = res_bi_q;
        valid_d    = valid_q;
        out_data_d = out_data_q;
        out_pe_d   = out_pe_q;
        out_fe_d   = out_fe_q;
        out_bi_d   = out_bi_q;
        overrun_d  = 1'b0;

        bit_done      = baud_tick_i && (tick_cnt_q == FULL_M1);
        last_data_bit = ({1'b0, bit_cnt_q} == wls_to_bits(wls_q) - 4'd1);

        if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end

        // A pop in the same cycle frees the holding register for the new frame
        if (commit_q) begin
            if (!valid_q || rx_ready_i) begin
                valid_d    = 1'b1;
                out_data_d = data_q;
                out_pe_d   = res_pe_q;
                out_fe_d   = res_fe_q;
                out_bi_d   = res_bi_q;
            end else begin
                overrun_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (baud_tick_i) begin
                    if (tick_cnt_q == HALF_M1) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                            data_d    = '0;
                            acc_d     = 1'b0;
                            par_bit_d = 1'b0;
                            wls_d     = lcr_wls_i;
                            pen_d     = lcr_pen_i;
                            eps_d     = lcr_eps_i;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_done) begin
                    tick_cnt_d        = '0;
                    data_d[bit_cnt_q] = rx_s;
                    acc_d             = acc_q ^ rx_s;
                    if (last_data_bit) begin
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (baud_tick_i) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    tick_cnt_d = '0;
                    par_bit_d  = rx_s;
                    acc_d      = acc_q ^ rx_s;
                    state_d    = STOP;
                end else if (baud_tick_i) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    tick_cnt_d = '0;
                    res_pe_d   = pen_q & (acc_q ^ ~eps_q);
                    res_fe_d   = ~rx_s;
                    res_bi_d   = (data_q == 8'h00) && (!par_bit_q || !pen_q) && !rx_s;
                    commit_d   = 1'b1;
                    state_d    = IDLE;
                end else if (baud_tick_i) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            acc_q      <= 1'b0;
            par_bit_q  <= 1'b0;
            wls_q      <= WLS_8;
            pen_q      <= 1'b0;
            eps_q      <= 1'b0;
            commit_q   <= 1'b0;
            res_pe_q   <= 1'b0;
            res_fe_q   <= 1'b0;
            res_bi_q   <= 1'b0;
            valid_q    <= 1'b0;
            out_data_q <= '0;
            out_pe_q   <= 1'b0;
            out_fe_q   <= 1'b0;
            out_bi_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            acc_q      <= acc_d;
            par_bit_q  <= par_bit_d;
            wls_q      <= wls_d;
            pen_q      <= pen_d;
            eps_q      <= eps_d;
            commit_q   <= commit_d;
            res_pe_q   <= res_pe_d;
            res_fe_q   <= res_fe_d;
            res_bi_q   <= res_bi_d;
            valid_q    <= valid_d;
            out_data_q <= out_data_d;
            out_pe_q   <= out_pe_d;
            out_fe_q   <= out_fe_d;
            out_bi_q   <= out_bi_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_valid_o = valid_q;
    assign rx_data_o  = out_data_q;
    assign pe_o       = out_pe_q;
    assign fe_o       = out_fe_q;
    assign bi_o       = out_bi_q;
    assign overrun_o  = overrun_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - directed and randomized frame checks for uart_rx_engine
module tb_uart_rx_engine;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick_i = 1'b0;
    logic       rx_i = 1'b1;
    logic [1:0] lcr_wls_i = 2'b11;
    logic       lcr_pen_i = 1'b0;
    logic       lcr_eps_i = 1'b0;
    logic       rx_ready_i = 1'b1;
    logic       rx_valid_o;
    logic [7:0] rx_data_o;
    logic       pe_o, fe_o, bi_o, overrun_o, busy_o;

    int          n_total = 0;
    int          n_pass = 0;
    int          ovr_cycles = 0;
    logic [10:0] got_q[$];

    uart_rx_engine dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick_i (baud_tick_i),
        .rx_i        (rx_i),
        .lcr_wls_i   (lcr_wls_i),
        .lcr_pen_i   (lcr_pen_i),
        .lcr_eps_i   (lcr_eps_i),
        .rx_ready_i  (rx_ready_i),
        .rx_valid_o  (rx_valid_o),
        .rx_data_o   (rx_data_o),
        .pe_o        (pe_o),
        .fe_o        (fe_o),
        .bi_o        (bi_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    initial forever #5 clk = ~clk;

    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            baud_tick_i = (cnt == 3);
            cnt = (cnt + 1) % 4;
        end
    end

    // Every byte accepted by the FIFO side, as {data, pe, fe, bi}
    always @(negedge clk) begin
        if (!rst && rx_valid_o && rx_ready_i) got_q.push_back({rx_data_o, pe_o, fe_o, bi_o});
        if (!rst && overrun_o) ovr_cycles++;
    end

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] mask_bits(input logic [7:0] d, input int nbits);
        return d & 8'((9'd1 << nbits) - 9'd1);
    endfunction

    // Line value of the parity bit: correct for the chosen sense unless flipped
    function automatic logic par_line(input logic [7:0] m, input bit eps, input bit flip);
        logic odd_ones = ($countones(m) % 2) == 1;
        logic p = eps ? odd_ones : !odd_ones;
        return flip ? !p : p;
    endfunction

    function automatic logic [10:0] model(input logic [7:0] d, input int nbits, input bit pen,
                                          input bit eps, input bit flip, input bit stop_v);
        logic [7:0] m = mask_bits(d, nbits);
        logic p = par_line(m, eps, flip);
        int total = $countones(m) + (pen ? int'(p) : 0);
        logic pe = pen && (eps ? (total % 2 == 1) : (total % 2 == 0));
        logic fe = !stop_v;
        logic bi = (m == 8'h00) && (!pen || !p) && !stop_v;
        return {m, pe, fe, bi};
    endfunction

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen, input bit eps,
                              input bit flip, input bit stop_v);
        logic [7:0] m = mask_bits(d, nbits);
        lcr_wls_i = 2'(nbits - 5);
        lcr_pen_i = pen;
        lcr_eps_i = eps;
        rx_i = 1'b0;
        wait_clk(BIT_CLKS);
        for (int i = 0; i < nbits; i++) begin
            rx_i = m[i];
            wait_clk(BIT_CLKS);
        end
        if (pen) begin
            rx_i = par_line(m, eps, flip);
            wait_clk(BIT_CLKS);
        end
        rx_i = stop_v;
        wait_clk(BIT_CLKS);
        rx_i = 1'b1;
        wait_clk(BIT_CLKS / 2);
    endtask

    task automatic expect_one(input string tag, input logic [10:0] exp);
        logic [10:0] g;
        check({tag, " count"}, got_q.size(), 1);
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            check({tag, " data"}, g[10:3], exp[10:3]);
            check({tag, " pe"}, g[2], exp[2]);
            check({tag, " fe"}, g[1], exp[1]);
            check({tag, " bi"}, g[0], exp[0]);
        end
        got_q.delete();
    endtask

    initial begin
        wait_clk(5);
        check("reset valid", rx_valid_o, 0);
        check("reset data", rx_data_o, 0);
        check("reset flags", {pe_o, fe_o, bi_o, overrun_o}, 0);
        check("reset busy", busy_o, 0);
        rst = 1'b0;
        wait_clk(10);

        send_frame(8'hA5, 8, 0, 0, 0, 1);
        expect_one("8N1 A5", model(8'hA5, 8, 0, 0, 0, 1));

        send_frame(8'h35, 7, 1, 1, 1, 1);
        expect_one("7E1 35 bad par", {8'h35, 1'b1, 1'b0, 1'b0});
        send_frame(8'h35, 7, 1, 1, 0, 1);
        expect_one("7E1 35 good par", {8'h35, 1'b0, 1'b0, 1'b0});

        // Start glitch: 4 ticks low is rejected at the half-bit resample
        rx_i = 1'b0;
        wait_clk(16);
        rx_i = 1'b1;
        wait_clk(3 * BIT_CLKS);
        check("glitch no byte", got_q.size(), 0);
        check("glitch idle", busy_o, 0);
        send_frame(8'h5A, 8, 0, 0, 0, 1);
        expect_one("after glitch 5A", model(8'h5A, 8, 0, 0, 0, 1));

        // Overrun while the FIFO is full
        rx_ready_i = 1'b0;
        ovr_cycles = 0;
        send_frame(8'h11, 8, 0, 0, 0, 1);
        send_frame(8'h22, 8, 0, 0, 0, 1);
        check("ovr held valid", rx_valid_o, 1);
        check("ovr held data", rx_data_o, 8'h11);
        check("ovr pulse width", ovr_cycles, 1);
        rx_ready_i = 1'b1;
        wait_clk(4);
        check("ovr popped valid", rx_valid_o, 0);
        expect_one("ovr pop 11", model(8'h11, 8, 0, 0, 0, 1));

        // Break: 12 bit-times low, then no retrigger until the line goes high
        lcr_wls_i = 2'b11;
        lcr_pen_i = 1'b0;
        rx_i = 1'b0;
        wait_clk(12 * BIT_CLKS);
        check("break idle while low", busy_o, 0);
        expect_one("break", {8'h00, 1'b0, 1'b1, 1'b1});
        wait_clk(4 * BIT_CLKS);
        check("break no retrigger", got_q.size(), 0);
        rx_i = 1'b1;
        wait_clk(BIT_CLKS);
        send_frame(8'hC3, 8, 0, 0, 0, 1);
        expect_one("after break C3", model(8'hC3, 8, 0, 0, 0, 1));

        // Reset in the middle of a 5N1 frame
        send_frame(8'h1F, 5, 0, 0, 0, 1);
        expect_one("5N1 1F", model(8'h1F, 5, 0, 0, 0, 1));
        rx_i = 1'b0;
        wait_clk(BIT_CLKS);
        rx_i = 1'b0;
        wait_clk(BIT_CLKS);
        rx_i = 1'b1;
        wait_clk(BIT_CLKS / 2);
        check("midframe busy", busy_o, 1);
        rst = 1'b1;
        wait_clk(1);
        check("rst valid", rx_valid_o, 0);
        check("rst data", rx_data_o, 0);
        check("rst flags", {pe_o, fe_o, bi_o, overrun_o}, 0);
        check("rst busy", busy_o, 0);
        rst = 1'b0;
        rx_i = 1'b1;
        wait_clk(3 * BIT_CLKS);
        check("rst no stray byte", got_q.size(), 0);
        send_frame(8'h0A, 5, 0, 0, 0, 1);
        expect_one("after rst 0A", model(8'h0A, 5, 0, 0, 0, 1));

        // Randomized frame formats against the reference model
        for (int k = 0; k < 12; k++) begin
            logic [7:0] d = 8'($urandom);
            int nb = 5 + int'($urandom_range(0, 3));
            bit pen = 1'($urandom);
            bit eps = 1'($urandom);
            bit flip = 1'($urandom);
            bit stop_v = ($urandom_range(0, 3) != 0);
            send_frame(d, nb, pen, eps, flip, stop_v);
            expect_one($sformatf("rand%0d", k), model(d, nb, pen, eps, flip, stop_v));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
